// File: rtl/pll_ce_nco_bank.sv
// Bank of phase-accumulator clock-enable generators sharing one clock, with
// shadowed increments committed atomically and a settle/lock status output.
module pll_ce_nco_bank #(
  parameter int NUM_CH = 5,
  parameter int ACC_W = 32,
  parameter int LOCK_CYCLES = 16,
  parameter logic [NUM_CH*ACC_W-1:0] INC_INIT = '0,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic              cfg_commit,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] tgl,
  output logic              locked
);
  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic {SETTLE, LOCKED} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [ACC_W-1:0]  shadow [NUM_CH];
  logic [ACC_W-1:0]  active [NUM_CH];
  logic [ACC_W-1:0]  acc [NUM_CH];
  logic [ACC_W:0]    sum [NUM_CH];
  logic [NUM_CH-1:0] wr_hit;
  logic              wr_ok;

  assign wr_ok = cfg_we && (32'(cfg_ch) < NUM_CH);

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = wr_ok && (cfg_ch == CH_W'(i));
      sum[i] = {1'b0, acc[i]} + {1'b0, active[i]};
    end
  end

  // A commit restarts the settle count from any state.
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    if (cfg_commit) begin
      state_nx = SETTLE;
      cnt_nx = '0;
    end else if (state == SETTLE) begin
      if (cnt == CNT_LAST) state_nx = LOCKED;
      else cnt_nx = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SETTLE;
      cnt <= '0;
      locked <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      locked <= (state_nx == LOCKED);
      cfg_err <= cfg_we && !wr_ok;
    end
  end

  // A write landing with a commit is forwarded straight into the active set.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= INC_INIT[i*ACC_W +: ACC_W];
        active[i] <= INC_INIT[i*ACC_W +: ACC_W];
        acc[i] <= '0;
      end
      ce <= '0;
      tgl <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_hit[i]) shadow[i] <= cfg_inc;
        if (cfg_commit) begin
          active[i] <= wr_hit[i] ? cfg_inc : shadow[i];
          acc[i] <= '0;
          ce[i] <= 1'b0;
        end else if (state == LOCKED) begin
          acc[i] <= sum[i][ACC_W-1:0];
          ce[i] <= sum[i][ACC_W];
          tgl[i] <= tgl[i] ^ sum[i][ACC_W];
        end else begin
          acc[i] <= '0;
          ce[i] <= 1'b0;
        end
      end
    end
  end
endmodule
